// File: rtl/regfile_run_checker.sv
// Run controller: enables the datapath for RUN_CYCLES cycles, then scans the register file
// against an expected-value source and reports a verdict. Optional macro: REGCHK_FIRST_ERR_EN.
module regfile_run_checker #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int RUN_CYCLES = 20,
    parameter int IDXW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            core_run,
    output logic [IDXW-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic [IDXW-1:0] exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic            exp_valid,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IDXW:0]   err_count
`ifdef REGCHK_FIRST_ERR_EN
    ,
    output logic [IDXW-1:0] first_err_idx,
    output logic [XLEN-1:0] first_err_val
`endif
);

    localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0]   RUN_LAST = CW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cyc;
    logic [IDXW-1:0] idx;
    logic            mismatch;

    // x0 is hardwired, so it is always checked against zero regardless of the expected store.
    function automatic logic is_mismatch(input logic [IDXW-1:0] i,
                                         input logic [XLEN-1:0] obs,
                                         input logic [XLEN-1:0] exp,
                                         input logic            vld);
        if (i == '0)
            return obs != '0;
        return vld && (obs != exp);
    endfunction

    assign mismatch = (state == SCAN) && is_mismatch(idx, dbg_data, exp_data, exp_valid);
    assign dbg_addr = idx;
    assign exp_addr = idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cyc       <= '0;
            idx       <= '0;
            core_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef REGCHK_FIRST_ERR_EN
            first_err_idx <= '0;
            first_err_val <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cyc       <= '0;
                        idx       <= '0;
                        err_count <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
`ifdef REGCHK_FIRST_ERR_EN
                        first_err_idx <= '0;
                        first_err_val <= '0;
`endif
                        if (RUN_CYCLES == 0) begin
                            state    <= SCAN;
                            core_run <= 1'b0;
                        end else begin
                            state    <= RUN;
                            core_run <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cyc == RUN_LAST) begin
                        state    <= SCAN;
                        core_run <= 1'b0;
                        idx      <= '0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                SCAN: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
`ifdef REGCHK_FIRST_ERR_EN
                        if (err_count == '0) begin
                            first_err_idx <= idx;
                            first_err_val <= dbg_data;
                        end
`endif
                    end
                    // The verdict must include the compare happening in this same cycle.
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_run_checker.sv
// Directed bench for regfile_run_checker: one instance with RUN_CYCLES=20 and one with
// RUN_CYCLES=0, sharing a modelled register file and expected-value store.
module tb_regfile_run_checker;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int IDXW  = 5;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;

    logic [XLEN-1:0] core_regs [NREGS];
    logic [XLEN-1:0] exp_mem   [NREGS];
    logic            exp_vld   [NREGS];

    logic            core_run_a, busy_a, done_a, pass_a;
    logic [IDXW-1:0] dbg_addr_a, exp_addr_a;
    logic [IDXW:0]   err_a;
    logic [XLEN-1:0] dbg_data_a, exp_data_a;
    logic            exp_valid_a;

    logic            core_run_b, busy_b, done_b, pass_b;
    logic [IDXW-1:0] dbg_addr_b, exp_addr_b;
    logic [IDXW:0]   err_b;
    logic [XLEN-1:0] dbg_data_b, exp_data_b;
    logic            exp_valid_b;

`ifdef REGCHK_FIRST_ERR_EN
    logic [IDXW-1:0] fidx_a, fidx_b;
    logic [XLEN-1:0] fval_a, fval_b;
`endif

    assign dbg_data_a  = core_regs[dbg_addr_a];
    assign exp_data_a  = exp_mem[exp_addr_a];
    assign exp_valid_a = exp_vld[exp_addr_a];
    assign dbg_data_b  = core_regs[dbg_addr_b];
    assign exp_data_b  = exp_mem[exp_addr_b];
    assign exp_valid_b = exp_vld[exp_addr_b];

    always #5 clk = ~clk;

    regfile_run_checker #(.XLEN(XLEN), .NREGS(NREGS), .RUN_CYCLES(20)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .core_run(core_run_a),
        .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a), .exp_addr(exp_addr_a),
        .exp_data(exp_data_a), .exp_valid(exp_valid_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a)
`ifdef REGCHK_FIRST_ERR_EN
        , .first_err_idx(fidx_a), .first_err_val(fval_a)
`endif
    );

    regfile_run_checker #(.XLEN(XLEN), .NREGS(NREGS), .RUN_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .core_run(core_run_b),
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b), .exp_addr(exp_addr_b),
        .exp_data(exp_data_b), .exp_valid(exp_valid_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b)
`ifdef REGCHK_FIRST_ERR_EN
        , .first_err_idx(fidx_b), .first_err_val(fval_b)
`endif
    );

    int tests = 0;
    int fails = 0;
    int lat, runs, addr_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_matching();
        for (int i = 0; i < NREGS; i++) begin
            core_regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0101;
            exp_mem[i]   = core_regs[i];
            exp_vld[i]   = 1'b1;
        end
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Starts right after the edge that sampled start; lat = edges until done is seen.
    task automatic wait_done(input bit sel_b, input int pulse_at,
                             output int lat_o, output int runs_o, output int bad_o);
        lat_o  = 0;
        runs_o = 0;
        bad_o  = 0;
        while (!(sel_b ? done_b : done_a) && lat_o < 200) begin
            if (sel_b ? core_run_b : core_run_a) runs_o++;
            if (sel_b ? (exp_addr_b !== dbg_addr_b) : (exp_addr_a !== dbg_addr_a)) bad_o++;
            if (lat_o == pulse_at) begin
                if (sel_b) start_b = 1'b1; else start_a = 1'b1;
            end
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            lat_o++;
        end
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        set_matching();
        tick();
        tick();
        chk("rst_core_run", core_run_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_dbg_addr", dbg_addr_a, 0);
        chk("rst_exp_addr", exp_addr_a, 0);
        reset = 1'b1;
        tick();
        chk("idle_ignores_nothing", busy_a, 0);

        // All registers match
        pulse_start(1'b0);
        chk("run_first_core_run", core_run_a, 1);
        chk("run_first_busy", busy_a, 1);
        wait_done(1'b0, -1, lat, runs, addr_bad);
        chk("match_latency", 64'(lat), 52);
        chk("match_run_edges", 64'(runs), 20);
        chk("match_exp_addr_eq", 64'(addr_bad), 0);
        chk("match_pass", pass_a, 1);
        chk("match_err", err_a, 0);
        chk("match_busy", busy_a, 0);
        tick();
        chk("done_holds", done_a, 1);

        // x5 mismatches; x12 mismatches but is don't-care
        core_regs[5]  = 32'd9;
        exp_mem[5]    = 32'd7;
        core_regs[12] = 32'hDEAD_BEEF;
        exp_vld[12]   = 1'b0;
        pulse_start(1'b0);
        wait_done(1'b0, -1, lat, runs, addr_bad);
        chk("x5_latency", 64'(lat), 52);
        chk("x5_err", err_a, 1);
        chk("x5_pass", pass_a, 0);
`ifdef REGCHK_FIRST_ERR_EN
        chk("x5_first_idx", fidx_a, 5);
        chk("x5_first_val", fval_a, 9);
`endif

        // x0 reads nonzero while its expected entry is marked don't-care
        set_matching();
        core_regs[0] = 32'h1;
        exp_mem[0]   = 32'h1;
        exp_vld[0]   = 1'b0;
        pulse_start(1'b0);
        wait_done(1'b0, -1, lat, runs, addr_bad);
        chk("x0_err", err_a, 1);
        chk("x0_pass", pass_a, 0);
`ifdef REGCHK_FIRST_ERR_EN
        chk("x0_first_idx", fidx_a, 0);
        chk("x0_first_val", fval_a, 1);
`endif

        // Restart from DONE clears the count; a mid-SCAN start is ignored
        set_matching();
        pulse_start(1'b0);
        chk("restart_err_cleared", err_a, 0);
        chk("restart_done_low", done_a, 0);
        chk("restart_core_run", core_run_a, 1);
        wait_done(1'b0, 30, lat, runs, addr_bad);
        chk("midscan_latency", 64'(lat), 52);
        chk("midscan_run_edges", 64'(runs), 20);
        chk("midscan_pass", pass_a, 1);
        tick();
        tick();
        chk("midscan_no_restart", busy_a, 0);

        // RUN_CYCLES = 0
        pulse_start(1'b1);
        chk("rc0_core_run", core_run_b, 0);
        chk("rc0_busy", busy_b, 1);
        wait_done(1'b1, -1, lat, runs, addr_bad);
        chk("rc0_latency", 64'(lat), 32);
        chk("rc0_run_edges", 64'(runs), 0);
        chk("rc0_pass", pass_b, 1);

        // Reset during RUN at cycle 5
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_core_run", core_run_a, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrun_rst_core_run", core_run_a, 0);
        chk("midrun_rst_busy", busy_a, 0);
        chk("midrun_rst_err", err_a, 0);
        runs = 0;
        for (int i = 0; i < 40; i++) begin
            if (core_run_a) runs++;
            tick();
        end
        chk("midrun_rst_no_enables", 64'(runs), 0);
        chk("midrun_rst_done", done_a, 0);

        // Reset from DONE with a nonzero count
        core_regs[7] = 32'h5;
        pulse_start(1'b0);
        wait_done(1'b0, -1, lat, runs, addr_bad);
        chk("fail_err", err_a, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("done_rst_err", err_a, 0);
        chk("done_rst_done", done_a, 0);
        chk("done_rst_pass", pass_a, 0);
`ifdef REGCHK_FIRST_ERR_EN
        chk("done_rst_first_idx", fidx_a, 0);
        chk("done_rst_first_val", fval_a, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
